pic_host_sequencer: RTL and testbench

PIC_HOST_SEQUENCER -- requirements
Module: pic_host_sequencer

---
 rtl/pic_pkg.sv | 58 +++++
 rtl/pic_host_sequencer_if.sv | 23 ++
 rtl/pic_bus_timer.sv | 24 ++
 rtl/pic_host_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_pic_host_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259-style PIC host sequencer.
// Holds the FSM state enum, the write-step enum and ICW1 bit positions.
package pic_pkg;

  typedef enum logic [3:0] {
    IDLE,
    W_SETUP,
    W_STROBE,
    W_HOLD,
    NEXT,
    ACK1,
    GAP,
    ACK2,
    CAPTURE
  } state_t;

  typedef enum logic [2:0] {
    STEP_ICW1,
    STEP_ICW2,
    STEP_ICW3,
    STEP_ICW4,
    STEP_OCW1,
    STEP_EOI
  } step_t;

  localparam logic [7:0] OCW2_NS_EOI = 8'h20;

  localparam int ICW1_IC4  = 0;
  localparam int ICW1_SNGL = 1;

  // Successor in the init sequence; ICW3 exists only in cascade mode, ICW4 only when IC4 is set.
  function automatic step_t next_step(step_t cur, logic [7:0] icw1);
    step_t nxt;
    nxt = STEP_OCW1;
    case (cur)
      STEP_ICW1: nxt = STEP_ICW2;
      STEP_ICW2: begin
        if (!icw1[ICW1_SNGL]) begin
          nxt = STEP_ICW3;
        end else if (icw1[ICW1_IC4]) begin
          nxt = STEP_ICW4;
        end else begin
          nxt = STEP_OCW1;
        end
      end
      STEP_ICW3: begin
        if (icw1[ICW1_IC4]) begin
          nxt = STEP_ICW4;
        end else begin
          nxt = STEP_OCW1;
        end
      end
      default: nxt = STEP_OCW1;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/pic_host_sequencer_if.sv
// PIC-side bus bundle: chip select, strobes, address bit, data bus and INT line.
// master = host sequencer, slave = PIC device (or its model).
interface pic_host_sequencer_if;
  logic       cs_n;
  logic       wr_n;
  logic       rd_n;
  logic       inta_n;
  logic       a0;
  logic [7:0] data_out;
  logic       data_oe;
  logic [7:0] data_in;
  logic       int_in;

  modport master (
    output cs_n, wr_n, rd_n, inta_n, a0, data_out, data_oe,
    input  data_in, int_in
  );

  modport slave (
    input  cs_n, wr_n, rd_n, inta_n, a0, data_out, data_oe,
    output data_in, int_in
  );
endinterface

// File: rtl/pic_bus_timer.sv
// Loadable 4-bit down-counter; done is high while the count sits at zero.
module pic_bus_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       done
);

  logic [3:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= 4'd0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != 4'd0) begin
      count_reg <= count_reg - 4'd1;
    end
  end

  assign done = (count_reg == 4'd0);

endmodule

// File: rtl/pic_host_sequencer.sv
// Host-side sequencer for an 8259-style PIC: init writes, non-specific EOI, INTA cycles.
// Optional PIC_SEQ_AUTO_EOI_EN: every captured vector automatically queues an EOI write.
module pic_host_sequencer
  import pic_pkg::*;
#(
  parameter int WR_PULSE   = 2,
  parameter int INTA_PULSE = 2,
  parameter int INTA_GAP   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] icw1,
  input  logic [7:0] icw2,
  input  logic [7:0] icw3,
  input  logic [7:0] icw4,
  input  logic [7:0] ocw1,
  input  logic       eoi_req,
  output logic       busy,
  output logic       init_done,
  output logic [7:0] vector,
  output logic       vector_valid,
  pic_host_sequencer_if.master bus
);

  state_t     state_reg, state_next;
  step_t      step_reg, step_next;
  step_t      follow_step;
  logic [7:0] data_out_reg, data_out_next;
  logic       a0_reg, a0_next;
  logic       init_done_reg, init_done_next;
  logic       eoi_pending_reg, eoi_pending_next;
  logic       latch_bytes;
  logic       capture_vec;
  logic       write_next;
  logic [7:0] follow_byte;

  logic       cs_n_reg, wr_n_reg, rd_n_reg, inta_n_reg, data_oe_reg;
  logic       busy_reg, vector_valid_reg;
  logic [7:0] vector_reg;

  logic       timer_load, timer_done;
  logic [3:0] timer_val;

  logic [4:0][7:0] byte_in;
  logic [4:0][7:0] byte_q;

  assign byte_in = {ocw1, icw4, icw3, icw2, icw1};

  // Init bytes are captured on the accepted start so later input changes cannot disturb the sequence.
  for (genvar gi = 0; gi < 5; gi++) begin : g_byte
    logic [7:0] byte_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        byte_reg <= 8'h00;
      end else if (latch_bytes) begin
        byte_reg <= byte_in[gi];
      end
    end
    assign byte_q[gi] = byte_reg;
  end

  assign follow_step = next_step(step_reg, byte_q[0]);

  always_comb begin
    follow_byte = byte_q[4];
    case (follow_step)
      STEP_ICW2: follow_byte = byte_q[1];
      STEP_ICW3: follow_byte = byte_q[2];
      STEP_ICW4: follow_byte = byte_q[3];
      default:   follow_byte = byte_q[4];
    endcase
  end

  pic_bus_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    step_next        = step_reg;
    data_out_next    = data_out_reg;
    a0_next          = a0_reg;
    init_done_next   = init_done_reg;
    eoi_pending_next = eoi_pending_reg | eoi_req;
    latch_bytes      = 1'b0;
    capture_vec      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          latch_bytes      = 1'b1;
          init_done_next   = 1'b0;
          eoi_pending_next = 1'b0;
          step_next        = STEP_ICW1;
          data_out_next    = icw1;
          a0_next          = 1'b0;
          state_next       = W_SETUP;
        end else if (eoi_pending_reg) begin
          eoi_pending_next = 1'b0;
          step_next        = STEP_EOI;
          data_out_next    = OCW2_NS_EOI;
          a0_next          = 1'b0;
          state_next       = W_SETUP;
        end else if (init_done_reg && bus.int_in) begin
          state_next = ACK1;
        end
      end
      W_SETUP:  state_next = W_STROBE;
      W_STROBE: if (timer_done) state_next = W_HOLD;
      W_HOLD:   state_next = NEXT;
      NEXT: begin
        if (step_reg == STEP_OCW1) begin
          init_done_next = 1'b1;
          state_next     = IDLE;
        end else if (step_reg == STEP_EOI) begin
          state_next = IDLE;
        end else begin
          step_next     = follow_step;
          data_out_next = follow_byte;
          a0_next       = 1'b1;
          state_next    = W_SETUP;
        end
      end
      ACK1: if (timer_done) state_next = GAP;
      GAP:  if (timer_done) state_next = ACK2;
      ACK2: begin
        if (timer_done) begin
          capture_vec = 1'b1;
          state_next  = CAPTURE;
        end
      end
      CAPTURE: begin
`ifdef PIC_SEQ_AUTO_EOI_EN
        eoi_pending_next = 1'b1;
`endif
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Every state change reloads the timer with the new state's duration minus one.
  always_comb begin
    timer_load = (state_next != state_reg);
    timer_val  = 4'd0;
    case (state_next)
      W_STROBE:   timer_val = 4'(WR_PULSE - 1);
      ACK1, ACK2: timer_val = 4'(INTA_PULSE - 1);
      GAP:        timer_val = 4'(INTA_GAP - 1);
      default:    timer_val = 4'd0;
    endcase
  end

  assign write_next = (state_next == W_SETUP) || (state_next == W_STROBE) ||
                      (state_next == W_HOLD);

  // Strobes are decoded from the next state and registered so they switch cleanly with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_reg         <= STEP_ICW1;
      data_out_reg     <= 8'h00;
      a0_reg           <= 1'b0;
      init_done_reg    <= 1'b0;
      eoi_pending_reg  <= 1'b0;
      cs_n_reg         <= 1'b1;
      wr_n_reg         <= 1'b1;
      rd_n_reg         <= 1'b1;
      inta_n_reg       <= 1'b1;
      data_oe_reg      <= 1'b0;
      busy_reg         <= 1'b0;
      vector_valid_reg <= 1'b0;
      vector_reg       <= 8'h00;
    end else begin
      step_reg         <= step_next;
      data_out_reg     <= data_out_next;
      a0_reg           <= a0_next;
      init_done_reg    <= init_done_next;
      eoi_pending_reg  <= eoi_pending_next;
      cs_n_reg         <= !write_next;
      wr_n_reg         <= !(state_next == W_STROBE);
      rd_n_reg         <= !(state_next == ACK2);
      inta_n_reg       <= !((state_next == ACK1) || (state_next == ACK2));
      data_oe_reg      <= write_next;
      busy_reg         <= (state_next != IDLE);
      vector_valid_reg <= (state_next == CAPTURE);
      if (capture_vec) begin
        vector_reg <= bus.data_in;
      end
    end
  end

  assign bus.cs_n     = cs_n_reg;
  assign bus.wr_n     = wr_n_reg;
  assign bus.rd_n     = rd_n_reg;
  assign bus.inta_n   = inta_n_reg;
  assign bus.a0       = a0_reg;
  assign bus.data_out = data_out_reg;
  assign bus.data_oe  = data_oe_reg;

  assign busy         = busy_reg;
  assign init_done    = init_done_reg;
  assign vector       = vector_reg;
  assign vector_valid = vector_valid_reg;

endmodule

// File: tb/tb_pic_host_sequencer.sv
// Scoreboard bench for pic_host_sequencer: expected writes/vectors queued at stimulus,
// bus monitor pops and compares them as the sequencer produces them.
module tb_pic_host_sequencer;

  localparam int WR_PULSE   = 2;
  localparam int INTA_PULSE = 2;
  localparam int INTA_GAP   = 1;
`ifdef PIC_SEQ_AUTO_EOI_EN
  localparam int AUTO_EOI = 1;
`else
  localparam int AUTO_EOI = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] icw1, icw2, icw3, icw4, ocw1;
  logic       eoi_req;
  logic       busy, init_done, vector_valid;
  logic [7:0] vector;
  logic       int_line;
  logic [7:0] pic_vec;

  pic_host_sequencer_if bus ();

  assign bus.int_in  = int_line;
  assign bus.data_in = bus.rd_n ? 8'hFF : pic_vec;

  pic_host_sequencer #(
    .WR_PULSE   (WR_PULSE),
    .INTA_PULSE (INTA_PULSE),
    .INTA_GAP   (INTA_GAP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .icw1         (icw1),
    .icw2         (icw2),
    .icw3         (icw3),
    .icw4         (icw4),
    .ocw1         (ocw1),
    .eoi_req      (eoi_req),
    .busy         (busy),
    .init_done    (init_done),
    .vector       (vector),
    .vector_valid (vector_valid),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_wr[$];
  logic [7:0] exp_vec[$];

  int writes = 0, inta_pulses = 0, busy_cycles = 0, bad_bus = 0, inta_early = 0;
  int wr_low = 0, cs_low = 0, inta_low = 0, rd_low = 0, since_high = 99, vv_len = 0;
  logic [8:0] wr_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Bus monitor: one pass per cycle, sampled on the falling edge.
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst_n) begin
      wr_low = 0; cs_low = 0; inta_low = 0; rd_low = 0; since_high = 99; vv_len = 0;
    end else begin
      if (busy) busy_cycles++;
      if (!bus.inta_n && !init_done) inta_early++;
      if (bus.cs_n && bus.data_oe) bad_bus++;

      if (!bus.wr_n) begin
        if (wr_low == 0) wr_seen = {bus.a0, bus.data_out};
        if (bus.cs_n || !bus.data_oe) bad_bus++;
        wr_low++;
      end else if (wr_low != 0) begin
        if (exp_wr.size() == 0) begin
          check("wr_unexpected", exp_wr.size(), 1);
        end else begin
          e = exp_wr.pop_front();
          check("wr_data", wr_seen[7:0], e[7:0]);
          check("wr_a0", wr_seen[8], e[8]);
        end
        check("wr_len", wr_low, WR_PULSE);
        writes++;
        wr_low = 0;
      end

      if (!bus.cs_n) begin
        if (bus.data_oe !== 1'b1) bad_bus++;
        cs_low++;
      end else if (cs_low != 0) begin
        check("cs_len", cs_low, WR_PULSE + 2);
        cs_low = 0;
      end

      if (!bus.inta_n) begin
        if (inta_low == 0 && !bus.rd_n) check("inta_gap", since_high, INTA_GAP);
        if (!bus.cs_n) bad_bus++;
        inta_low++;
        since_high = 0;
      end else begin
        if (inta_low != 0) begin
          check("inta_len", inta_low, INTA_PULSE);
          inta_pulses++;
          inta_low = 0;
        end
        since_high++;
      end

      if (!bus.rd_n) begin
        if (bus.inta_n) bad_bus++;
        rd_low++;
      end else if (rd_low != 0) begin
        check("rd_len", rd_low, INTA_PULSE);
        rd_low = 0;
      end

      if (vector_valid) begin
        if (exp_vec.size() == 0) check("vec_unexpected", exp_vec.size(), 1);
        else check("vector", vector, exp_vec.pop_front());
        vv_len++;
      end else if (vv_len != 0) begin
        check("vv_len", vv_len, 1);
        vv_len = 0;
      end
    end
  end

  task automatic push_init(input logic [7:0] i1, i2, i3, i4, o1);
    exp_wr.push_back({1'b0, i1});
    exp_wr.push_back({1'b1, i2});
    if (!i1[1]) exp_wr.push_back({1'b1, i3});
    if (i1[0])  exp_wr.push_back({1'b1, i4});
    exp_wr.push_back({1'b1, o1});
  endtask

  task automatic do_start(input logic [7:0] i1, i2, i3, i4, o1);
    @(negedge clk);
    icw1 = i1; icw2 = i2; icw3 = i3; icw4 = i4; ocw1 = o1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_quiet(input int budget);
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < budget) begin
      @(negedge clk);
      n++;
      if (busy) quiet = 0;
      else quiet++;
    end
    if (quiet < 4) check("quiet_timeout", quiet, 4);
  endtask

  task automatic wait_vv(input int budget);
    int n = 0;
    while (!vector_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!vector_valid) check("vv_timeout", vector_valid, 1);
  endtask

  task automatic pulse_eoi();
    @(negedge clk);
    eoi_req = 1'b1;
    @(negedge clk);
    eoi_req = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, i0, n;
    rst_n = 1'b0; start = 1'b0; eoi_req = 1'b0; int_line = 1'b0; pic_vec = 8'h00;
    icw1 = 8'h00; icw2 = 8'h00; icw3 = 8'h00; icw4 = 8'h00; ocw1 = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_cs_n", bus.cs_n, 1);
    check("rst_wr_n", bus.wr_n, 1);
    check("rst_rd_n", bus.rd_n, 1);
    check("rst_inta_n", bus.inta_n, 1);
    check("rst_a0", bus.a0, 0);
    check("rst_data_out", bus.data_out, 0);
    check("rst_data_oe", bus.data_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_init_done", init_done, 0);
    check("rst_vector", vector, 0);
    check("rst_vector_valid", vector_valid, 0);
    rst_n = 1'b1;

    // Single, ICW4 present: no ICW3 write
    w0 = writes;
    push_init(8'h13, 8'h08, 8'hAA, 8'h01, 8'hF0);
    busy_cycles = 0;
    do_start(8'h13, 8'h08, 8'hAA, 8'h01, 8'hF0);
    wait_quiet(200);
    check("a_init_done", init_done, 1);
    check("a_writes", writes - w0, 4);
    check("a_busy_cycles", busy_cycles, 4 * (WR_PULSE + 3));

    // Cascade: ICW3 written; a second start while busy is ignored
    w0 = writes;
    push_init(8'h11, 8'h40, 8'h04, 8'h03, 8'h0F);
    do_start(8'h11, 8'h40, 8'h04, 8'h03, 8'h0F);
    repeat (6) @(negedge clk);
    icw1 = 8'h5C; icw2 = 8'h99; icw3 = 8'h77; icw4 = 8'h66; ocw1 = 8'h55;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_quiet(300);
    check("b_writes", writes - w0, 5);
    check("b_init_done", init_done, 1);

    // Interrupt acknowledge
    w0 = writes; i0 = inta_pulses;
    pic_vec = 8'h0B;
    exp_vec.push_back(8'h0B);
    if (AUTO_EOI != 0) exp_wr.push_back({1'b0, 8'h20});
    int_line = 1'b1;
    wait_vv(100);
    int_line = 1'b0;
    wait_quiet(100);
    check("c_inta_pulses", inta_pulses - i0, 2);
    check("c_writes", writes - w0, AUTO_EOI);

    // Two EOI requests during INTA collapse into one write
    w0 = writes; i0 = inta_pulses;
    exp_vec.push_back(8'h0B);
    exp_wr.push_back({1'b0, 8'h20});
    int_line = 1'b1;
    n = 0;
    while (bus.inta_n && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("d_inta_seen", bus.inta_n, 0);
    pulse_eoi();
    pulse_eoi();
    wait_vv(100);
    int_line = 1'b0;
    wait_quiet(100);
    check("d_writes", writes - w0, 1);
    check("d_inta_pulses", inta_pulses - i0, 2);

    // EOI from idle
    w0 = writes;
    exp_wr.push_back({1'b0, 8'h20});
    pulse_eoi();
    wait_quiet(100);
    check("e_writes", writes - w0, 1);
    check("e_init_done", init_done, 1);

    // Asynchronous reset in the second strobe cycle
    push_init(8'h13, 8'h08, 8'hAA, 8'h01, 8'hF0);
    do_start(8'h13, 8'h08, 8'hAA, 8'h01, 8'hF0);
    n = 0;
    while (bus.wr_n && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("f_strobe_seen", bus.wr_n, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("f_wr_n", bus.wr_n, 1);
    check("f_cs_n", bus.cs_n, 1);
    check("f_data_oe", bus.data_oe, 0);
    check("f_init_done", init_done, 0);
    check("f_busy", busy, 0);
    repeat (2) @(negedge clk);
    exp_wr.delete();
    rst_n = 1'b1;

    // int_in ignored before init
    i0 = inta_pulses;
    int_line = 1'b1;
    repeat (10) @(negedge clk);
    check("g_ignored_inta", inta_pulses - i0, 0);
    check("g_ignored_busy", busy, 0);
    int_line = 1'b0;

    w0 = writes;
    push_init(8'h13, 8'h08, 8'hAA, 8'h01, 8'hF0);
    do_start(8'h13, 8'h08, 8'hAA, 8'h01, 8'hF0);
    wait_quiet(200);
    check("g_writes", writes - w0, 4);
    check("g_init_done", init_done, 1);

    // start and int_in together: init first, then INTA
    w0 = writes; i0 = inta_pulses; inta_early = 0;
    pic_vec = 8'h5A;
    push_init(8'h17, 8'h20, 8'h00, 8'h03, 8'hFE);
    exp_vec.push_back(8'h5A);
    if (AUTO_EOI != 0) exp_wr.push_back({1'b0, 8'h20});
    @(negedge clk);
    icw1 = 8'h17; icw2 = 8'h20; icw3 = 8'h00; icw4 = 8'h03; ocw1 = 8'hFE;
    start = 1'b1;
    int_line = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_vv(300);
    int_line = 1'b0;
    wait_quiet(100);
    check("h_inta_early", inta_early, 0);
    check("h_writes", writes - w0, 4 + AUTO_EOI);
    check("h_inta_pulses", inta_pulses - i0, 2);

    check("bus_protocol", bad_bus, 0);
    check("wr_queue_left", exp_wr.size(), 0);
    check("vec_queue_left", exp_vec.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
